dot_seq: RTL and testbench

- Operand sequencer sitting directly upstream of the 16-bit ALU in the matrix-multiplier datapath.
- On start, it fetches a row of A and a strided column of B from a synchronous operand memory.
- For each element pair it drives the ALU with MUL, then ADD, accumulating through the ALU's registered output.
- It presents the 16-bit dot product with a one-cycle done pulse; the matrix controller issues one dot_seq job per result element.

---
 rtl/dot_seq.sv | 134 +++++++++++++
 tb/tb_dot_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_seq.sv
// Dot-product operand sequencer: fetches A[i] and strided B[i] from a synchronous
// operand memory and drives the external ALU with MUL then ADD per element pair.
module dot_seq #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] stride_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       alu_in1,
    output logic [15:0]       alu_in2,
    output logic [2:0]        alu_control,
    input  logic [15:0]       alu_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result
);

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_MUL = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_B, S_LATCH_B, S_MUL, S_ADD, S_ACC, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q, k;
    logic [ADDR_W-1:0] stride_q, a_ptr, b_ptr;
    logic [15:0]       a_reg, b_reg, acc, result_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            k        <= '0;
            stride_q <= '0;
            a_ptr    <= '0;
            b_ptr    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= '0;
                        if (len != '0) begin
                            len_q    <= len;
                            stride_q <= stride_b;
                            a_ptr    <= base_a;
                            b_ptr    <= base_b;
                            k        <= '0;
                        end
                    end
                end
                S_FETCH_B: a_reg <= mem_rdata;
                S_LATCH_B: b_reg <= mem_rdata;
                S_ACC: begin
                    acc   <= alu_out;
                    a_ptr <= a_ptr + ADDR_W'(1);
                    b_ptr <= b_ptr + stride_q;
                    k     <= k + LEN_W'(1);
                end
                S_DONE:  result_q <= acc;
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        mem_addr    = '0;
        mem_rd      = 1'b0;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_control = ALU_NOP;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (len == '0) ? S_DONE : S_FETCH_A;
            end
            S_FETCH_A: begin
                mem_addr  = a_ptr;
                mem_rd    = 1'b1;
                state_nxt = S_FETCH_B;
            end
            S_FETCH_B: begin
                mem_addr  = b_ptr;
                mem_rd    = 1'b1;
                state_nxt = S_LATCH_B;
            end
            S_LATCH_B: state_nxt = S_MUL;
            S_MUL: begin
                alu_control = ALU_MUL;
                alu_in1     = a_reg;
                alu_in2     = b_reg;
                state_nxt   = S_ADD;
            end
            S_ADD: begin
                // The product is still sitting in the ALU output register.
                alu_control = ALU_ADD;
                alu_in1     = acc;
                alu_in2     = alu_out;
                state_nxt   = S_ACC;
            end
            S_ACC: begin
                state_nxt = (k == len_q - LEN_W'(1)) ? S_DONE : S_FETCH_A;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign result = (state == S_DONE) ? acc : result_q;

endmodule

// File: tb/tb_dot_seq.sv
// Scoreboard bench for dot_seq: memory and ALU models, reference dot product,
// decoupled monitor comparing result and done timing.
module tb_dot_seq;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [ADDR_W-1:0] base_a = '0, base_b = '0, stride_b = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata = '0;
    logic [15:0]       alu_in1, alu_in2, alu_out;
    logic [2:0]        alu_control;
    logic              busy, done;
    logic [15:0]       result;

    logic [15:0] mem [256];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [ADDR_W-1:0] addr_log[$];
    logic [2:0]        op_log[$];

    dot_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b), .stride_b(stride_b),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_out(alu_out), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous operand memory and registered 16-bit ALU.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
    always @(posedge clk or posedge rst) begin
        if (rst) alu_out <= '0;
        else if (alu_control == 3'b001) alu_out <= 16'(alu_in1 * alu_in2);
        else if (alu_control == 3'b010) alu_out <= 16'(alu_in1 + alu_in2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_dot(input int l, input int ba, input int bb, input int sbs);
        longint sum = 0;
        for (int i = 0; i < l; i++)
            sum += longint'(mem[(ba + i) % 256]) * longint'(mem[(bb + i * sbs) % 256]);
        return 16'(sum);
    endfunction

    // Monitor: logs memory/ALU activity and checks each done against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd) addr_log.push_back(mem_addr);
            if (alu_control != 3'b000) op_log.push_back(alu_control);
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cyc=%0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", 32'(result), 32'(mon_e.res));
                    check("done_cycle", cyc, mon_e.cyc);
                    check("busy_at_done", 32'(busy), 1);
                end
            end
        end
    end

    task automatic run_job(input int l, input int ba, input int bb, input int sbs,
                           input int busy_start_at, input bit done_start);
        int e0, waited;
        logic [15:0] exp_res;
        logic [ADDR_W-1:0] exp_addr[$];
        addr_log.delete();
        op_log.delete();
        start    = 1'b1;
        len      = LEN_W'(l);
        base_a   = ADDR_W'(ba);
        base_b   = ADDR_W'(bb);
        stride_b = ADDR_W'(sbs);
        exp_res  = ref_dot(l, ba, bb, sbs);
        @(posedge clk); #1;
        e0 = cyc;
        sb.push_back('{exp_res, e0 + 6 * l});
        start    = 1'b0;
        len      = LEN_W'($urandom);
        base_a   = ADDR_W'($urandom);
        base_b   = ADDR_W'($urandom);
        stride_b = ADDR_W'($urandom);
        waited   = 0;
        while (sb.size() != 0 && waited < 6 * l + 20) begin
            if (busy_start_at > 0 && cyc == e0 + busy_start_at - 1) begin
                start = 1'b1;
                len   = LEN_W'(l + 1);
            end else if (done_start && cyc == e0 + 6 * l) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            waited++;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done expected done within %0d cycles", 6 * l + 20);
            sb.delete();
        end
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back(ADDR_W'((ba + i) % 256));
            exp_addr.push_back(ADDR_W'((bb + i * sbs) % 256));
        end
        check("addr_count", addr_log.size(), 2 * l);
        for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
            check("mem_addr", 32'(addr_log[i]), 32'(exp_addr[i]));
        check("op_count", op_log.size(), 2 * l);
        for (int i = 0; i < op_log.size(); i++)
            check("alu_op", 32'(op_log[i]), (i % 2 == 0) ? 1 : 2);
        check("result_held", 32'(result), 32'(exp_res));
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int e0;
        foreach (mem[i]) mem[i] = 16'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {23'd0, mem_addr, mem_rd}, 0);
        check("reset_alu", {alu_in1, alu_in2}, 0);
        check("reset_misc", {alu_control, busy, done, result}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic dot product
        mem['h10] = 1; mem['h11] = 2; mem['h12] = 3;
        mem['h20] = 4; mem['h21] = 5; mem['h22] = 6;
        run_job(3, 'h10, 'h20, 1, 0, 0);
        check("basic_value", 32'(result), 32);

        // Column stride
        mem['h10] = 1; mem['h11] = 1; mem['h12] = 1;
        mem['h20] = 7; mem['h24] = 8; mem['h28] = 9;
        run_job(3, 'h10, 'h20, 4, 0, 0);
        check("stride_value", 32'(result), 24);

        // Overflow wrap
        mem['h30] = 300; mem['h40] = 300;
        run_job(1, 'h30, 'h40, 1, 0, 0);
        check("wrap_value", 32'(result), 24464);

        // Zero length, with start held in the DONE cycle
        run_job(0, 'h55, 'h66, 1, 0, 1);
        check("zero_value", 32'(result), 0);

        // Address wrap plus start while busy
        run_job(3, 'hFE, 'h50, 3, 5, 0);

        // Reset during the second element's MUL cycle
        mem['h70] = 3; mem['h71] = 4; mem['h80] = 5; mem['h81] = 6;
        start = 1'b1; len = 2; base_a = 'h70; base_b = 'h80; stride_b = 1;
        @(posedge clk); #1;
        e0 = cyc;
        sb.push_back('{ref_dot(2, 'h70, 'h80, 1), e0 + 12});
        start = 1'b0;
        while (cyc < e0 + 9) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 32'(busy), 1);
        check("mid_mul", 32'(alu_control), 1);
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_ctl", {23'd0, mem_addr, mem_rd}, 0);
        check("midrst_alu", {alu_in1, alu_in2}, 0);
        check("midrst_misc", {alu_control, busy, done, result}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("after_rst_idle", {busy, result}, 0);
        run_job(2, 'h70, 'h80, 1, 0, 0);
        check("fresh_value", 32'(result), 39);

        // Randomized jobs
        repeat (12) begin
            run_job($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? 3 : 0,
                    1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
